ps2_key_ctrl: RTL

- Sequencing controller between the PS/2 receiver FIFO (ready/data/nextdata_n handshake) and display/ASCII logic.
- Pops one scan-code byte at a time and decodes make, break (F0), extended (E0) and typematic-repeat sequences.
- Tracks shift, ctrl and caps-lock state, and counts completed keystrokes.
- Emits one-cycle key events to downstream 7-segment and ROM logic.

---
 rtl/ps2_key_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops bytes from the receiver FIFO, decodes make/break/extended
// sequences, tracks modifier state and emits one-cycle key events.
module ps2_key_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter logic [7:0]  HOLD_IDLE = 8'h00
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             make_p,
  output logic             rpt_p,
  output logic             brk_p,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeBrk    = 8'hF0;
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;
  localparam logic [7:0] CodeCtrl   = 8'h14;
  localparam logic [7:0] CodeCaps   = 8'h58;

  typedef enum logic [1:0] {FIdle, FPop, FGap} fetch_e;
  typedef enum logic [1:0] {DBase, DExt, DBrk, DExtBrk} dec_e;

  fetch_e fetch_q, fetch_d;
  dec_e   dec_q, dec_d;

  logic [7:0]       byte_q;
  logic             handoff;
  logic             is_make, is_brk, cur_ext, proto_err;
  logic             held_match;

  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             make_q, make_d;
  logic             rpt_q, rpt_d;
  logic             brk_q, brk_d;
  logic             lsh_q, lsh_d;
  logic             rsh_q, rsh_d;
  logic             ctrl_q, ctrl_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Fetch FSM: state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_q <= FIdle;
    end else begin
      fetch_q <= fetch_d;
    end
  end

  // Fetch FSM: next state
  always_comb begin
    fetch_d = fetch_q;
    unique case (fetch_q)
      FIdle:   if (ready) fetch_d = FPop;
      FPop:    fetch_d = FGap;
      FGap:    fetch_d = FIdle;
      default: fetch_d = FIdle;
    endcase
  end

  // Fetch FSM: outputs; an overflow in the pop cycle discards the byte
  always_comb begin
    nextdata_n = (fetch_q != FPop);
    handoff    = (fetch_q == FPop) && !overflow;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      byte_q <= 8'h00;
    end else if (fetch_q == FIdle && ready) begin
      byte_q <= data;
    end
  end

  // Decode FSM: state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dec_q <= DBase;
    end else begin
      dec_q <= dec_d;
    end
  end

  // Decode FSM: next state and decoded action
  always_comb begin
    dec_d     = dec_q;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    cur_ext   = 1'b0;
    proto_err = 1'b0;
    if (overflow) begin
      dec_d = DBase;
    end else if (handoff) begin
      unique case (dec_q)
        DBase: begin
          if (byte_q == CodeExt) begin
            dec_d = DExt;
          end else if (byte_q == CodeBrk) begin
            dec_d = DBrk;
          end else begin
            is_make = 1'b1;
          end
        end
        DExt: begin
          if (byte_q == CodeBrk) begin
            dec_d = DExtBrk;
          end else if (byte_q == CodeExt) begin
            proto_err = 1'b1;
          end else begin
            is_make = 1'b1;
            cur_ext = 1'b1;
            dec_d   = DBase;
          end
        end
        DBrk, DExtBrk: begin
          dec_d = DBase;
          if (byte_q == CodeExt || byte_q == CodeBrk) begin
            proto_err = 1'b1;
          end else begin
            is_brk  = 1'b1;
            cur_ext = (dec_q == DExtBrk);
          end
        end
        default: dec_d = DBase;
      endcase
    end
  end

  // Decode FSM: key state and event outputs
  always_comb begin
    code_d     = code_q;
    ext_d      = ext_q;
    make_d     = 1'b0;
    rpt_d      = 1'b0;
    brk_d      = 1'b0;
    lsh_d      = lsh_q;
    rsh_d      = rsh_q;
    ctrl_d     = ctrl_q;
    caps_d     = caps_q;
    count_d    = count_q;
    err_d      = err_q | proto_err | overflow;
    held_match = (byte_q == code_q) && (cur_ext == ext_q);

    if (is_make) begin
      case (byte_q)
        CodeLShift: lsh_d  = 1'b1;
        CodeRShift: rsh_d  = 1'b1;
        CodeCtrl:   ctrl_d = 1'b1;
        default: begin
          if (held_match) begin
            rpt_d = 1'b1;
          end else begin
            if (byte_q == CodeCaps && !cur_ext) caps_d = ~caps_q;
            code_d = byte_q;
            ext_d  = cur_ext;
            make_d = 1'b1;
          end
        end
      endcase
    end

    if (is_brk) begin
      case (byte_q)
        CodeLShift: lsh_d  = 1'b0;
        CodeRShift: rsh_d  = 1'b0;
        CodeCtrl:   ctrl_d = 1'b0;
        default: begin
          if (held_match) begin
            brk_d   = 1'b1;
            count_d = count_q + CNT_W'(1);
            code_d  = HOLD_IDLE;
            ext_d   = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      code_q  <= HOLD_IDLE;
      ext_q   <= 1'b0;
      make_q  <= 1'b0;
      rpt_q   <= 1'b0;
      brk_q   <= 1'b0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      caps_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      ext_q   <= ext_d;
      make_q  <= make_d;
      rpt_q   <= rpt_d;
      brk_q   <= brk_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      ctrl_q  <= ctrl_d;
      caps_q  <= caps_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign key_code = code_q;
  assign key_ext  = ext_q;
  assign make_p   = make_q;
  assign rpt_p    = rpt_q;
  assign brk_p    = brk_q;
  assign shift    = lsh_q | rsh_q;
  assign ctrl     = ctrl_q;
  assign caps     = caps_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule
